pipe_stage_hs: RTL and testbench

//  Generic valid/ready pipeline stage register. It replaces the fixed per-field dff_sync banks

---
 rtl/pipe_stage_hs.sv | 118 +++++++++++
 tb/tb_pipe_stage_hs.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - valid/ready pipeline stage register with stall, flush and optional skid slot
`timescale 1ns/1ps
module pipe_stage_hs #(
  parameter int unsigned       DATA_W      = 32*4+5*3,
  parameter int unsigned       CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter bit                SKID_EN     = 1'b1
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o
);

  // MAIN always drives the outputs; SKID only holds a beat while MAIN is blocked.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

  logic main_valid;
  logic skid_valid;
  logic go;
  logic drain;
  logic acc;

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_FULL);
  assign go         = out_ready_i & ~stall_i;
  assign drain      = main_valid & go;

  // With the skid slot, ready comes straight from state so the downstream ready path is cut.
  assign in_ready_o = (SKID_EN != 1'b0) ? ~skid_valid : (~main_valid | go);
  assign acc        = in_valid_i & in_ready_o;

  assign out_valid_o = main_valid;
  assign out_data_o  = main_data_q;
  assign out_ctrl_o  = main_valid ? main_ctrl_q : CTRL_BUBBLE;
  assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

  // Next-state and slot loads; flush overrides every other event, payload keeps its last value.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d     = ST_ONE;
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end
        end
        ST_ONE: begin
          if (drain && acc) begin
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end else if (acc && (SKID_EN != 1'b0)) begin
            state_d     = ST_FULL;
            skid_data_d = in_data_i;
            skid_ctrl_d = in_ctrl_i;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and slot registers; reset discards everything without waiting for a clock.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - scoreboard bench for pipe_stage_hs (skid and no-skid variants)
`timescale 1ns/1ps
module tb_pipe_stage_hs;

  localparam int DW = 32*4+5*3;
  localparam int CW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, stall, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occ;

  logic          flush0, stall0, v0, ordy0;
  logic          in_ready0, out_valid0;
  logic [DW-1:0] d0, out_data0;
  logic [CW-1:0] c0, out_ctrl0;
  logic [1:0]    occ0;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb_q[$];

  always #5 clk = ~clk;

  pipe_stage_hs dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ctrl_o(out_ctrl), .occupancy_o(occ)
  );

  pipe_stage_hs #(.SKID_EN(1'b0)) dut0 (
    .sys_clk_i(clk), .rst_n_i(rst_n), .flush_i(flush0), .stall_i(stall0),
    .in_valid_i(v0), .in_ready_o(in_ready0), .in_data_i(d0), .in_ctrl_i(c0),
    .out_valid_o(out_valid0), .out_ready_i(ordy0), .out_data_o(out_data0),
    .out_ctrl_o(out_ctrl0), .occupancy_o(occ0)
  );

  function automatic logic [DW-1:0] mk(input int unsigned v);
    logic [DW-1:0] r;
    r = '0;
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] v);
    return {1'b1, v[14:0]};
  endfunction

  task automatic drive(input logic iv, input int unsigned dv, input logic st,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = mk(dv);
    in_ctrl   = ctrl_of(mk(dv));
    stall     = st;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples mid-cycle, applies what the coming edge will do.
  initial begin
    beat_t         exp_b;
    logic          hold_pend;
    logic [DW-1:0] hold_d;
    logic [CW-1:0] hold_c;
    logic          go_s;
    hold_pend = 1'b0;
    hold_d    = '0;
    hold_c    = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        sb_q.delete();
        hold_pend = 1'b0;
      end else begin
        n_checks++;
        if ({30'd0, occ} !== sb_q.size()) begin
          n_fail++;
          $display("FAIL occupancy_vs_model: got %0d expected %0d at %0t", occ, sb_q.size(), $time);
        end
        if (out_valid === 1'b0) begin
          n_checks++;
          if (out_ctrl !== '0) begin
            n_fail++;
            $display("FAIL bubble_ctrl: got %h expected 0 at %0t", out_ctrl, $time);
          end
        end
        if (hold_pend) begin
          n_checks++;
          if (out_valid !== 1'b1 || out_data !== hold_d || out_ctrl !== hold_c) begin
            n_fail++;
            $display("FAIL stall_stable: got v=%b d=%h c=%h expected v=1 d=%h c=%h at %0t",
                     out_valid, out_data, out_ctrl, hold_d, hold_c, $time);
          end
        end
        hold_pend = 1'b0;
        go_s = out_ready & ~stall;
        if (flush) begin
          sb_q.delete();
        end else begin
          if (out_valid && go_s) begin
            n_checks++;
            if (sb_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_beat: got d=%h with empty model at %0t", out_data, $time);
            end else begin
              exp_b = sb_q.pop_front();
              if (out_data !== exp_b.d || out_ctrl !== exp_b.c) begin
                n_fail++;
                $display("FAIL beat_order: got d=%h c=%h expected d=%h c=%h at %0t",
                         out_data, out_ctrl, exp_b.d, exp_b.c, $time);
              end
            end
          end
          if (in_valid && in_ready) sb_q.push_back('{d: in_data, c: in_ctrl});
          if (out_valid && !go_s) begin
            hold_pend = 1'b1;
            hold_d    = out_data;
            hold_c    = out_ctrl;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    v0 = 0; d0 = '0; c0 = '0; ordy0 = 0; stall0 = 0; flush0 = 0;
    repeat (2) cyc();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0 || occ !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h c=%h occ=%0d rdy=%b expected 0/0/0/0/1",
               out_valid, out_data, out_ctrl, occ, in_ready);
    end
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b1 || in_ready0 !== 1'b1 || occ0 !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got v=%b occ=%0d rdy=%b rdy0=%b occ0=%0d expected 0/0/1/1/0",
               out_valid, occ, in_ready, in_ready0, occ0);
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, 0, 1, 0);
      cyc();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== mk(i) || occ !== 2'd1 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: got v=%b d=%h occ=%0d rdy=%b expected 1/%0d/1/1",
                 i, out_valid, out_data, occ, in_ready, i);
      end
    end
    drive(0, 0, 0, 1, 0);
    cyc();
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0) begin
      n_fail++;
      $display("FAIL stream_drain: got v=%b occ=%0d expected 0/0", out_valid, occ);
    end
  endtask

  task automatic test_skid();
    drive(1, 'hA, 0, 1, 0);
    cyc();
    drive(1, 'hB, 1, 1, 0);
    cyc();
    n_checks++;
    if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== mk('hA) || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_full: got occ=%0d rdy=%b d=%h v=%b expected 2/0/A/1", occ, in_ready, out_data, out_valid);
    end
    drive(0, 0, 1, 1, 0);
    cyc();
    n_checks++;
    if (occ !== 2'd2 || out_data !== mk('hA)) begin
      n_fail++;
      $display("FAIL skid_hold: got occ=%0d d=%h expected 2/A", occ, out_data);
    end
    drive(0, 0, 0, 1, 0);
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== mk('hB) || occ !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_release: got v=%b d=%h occ=%0d rdy=%b expected 1/B/1/1", out_valid, out_data, occ, in_ready);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0) begin
      n_fail++;
      $display("FAIL skid_empty: got v=%b occ=%0d expected 0/0", out_valid, occ);
    end
  endtask

  task automatic test_flush();
    drive(1, 'hA, 1, 1, 0);
    cyc();
    drive(1, 'hB, 1, 1, 0);
    cyc();
    drive(1, 'hC, 1, 1, 1);
    cyc();
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || occ !== 2'd0 || in_ready !== 1'b1 || out_data !== mk('hA)) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b c=%h occ=%0d rdy=%b d=%h expected 0/0/0/1/A",
               out_valid, out_ctrl, occ, in_ready, out_data);
    end
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_c_%0d: got v=%b d=%h expected v=0", i, out_valid, out_data);
      end
    end
    drive(1, 'hA, 0, 0, 0);
    cyc();
    drive(1, 'hC, 0, 0, 1);
    cyc();
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_one_acc: got v=%b occ=%0d rdy=%b expected 0/0/1", out_valid, occ, in_ready);
    end
    drive(0, 0, 0, 1, 0);
    cyc();
  endtask

  task automatic test_reset_mid_full();
    drive(1, 'hD, 1, 1, 0);
    cyc();
    drive(1, 'hE, 1, 1, 0);
    cyc();
    n_checks++;
    if (occ !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_reset_full: got occ=%0d expected 2", occ);
    end
    drive(0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || occ !== 2'd0 || in_ready !== 1'b1 || out_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b c=%h occ=%0d rdy=%b d=%h expected 0/0/0/1/0",
               out_valid, out_ctrl, occ, in_ready, out_data);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_no_skid();
    v0 = 1; d0 = mk('hA); c0 = ctrl_of(mk('hA)); ordy0 = 1; stall0 = 0; flush0 = 0;
    cyc();
    n_checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== mk('hA) || occ0 !== 2'd1) begin
      n_fail++;
      $display("FAIL noskid_load: got v=%b d=%h occ=%0d expected 1/A/1", out_valid0, out_data0, occ0);
    end
    ordy0 = 0; d0 = mk('hB); c0 = ctrl_of(mk('hB));
    #1;
    n_checks++;
    if (in_ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL noskid_backpressure: got rdy=%b expected 0", in_ready0);
    end
    ordy0 = 1;
    #1;
    n_checks++;
    if (in_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL noskid_ready_comb: got rdy=%b expected 1", in_ready0);
    end
    cyc();
    n_checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== mk('hB) || out_ctrl0 !== ctrl_of(mk('hB)) || occ0 !== 2'd1) begin
      n_fail++;
      $display("FAIL noskid_replace: got v=%b d=%h c=%h occ=%0d expected 1/B/%h/1",
               out_valid0, out_data0, out_ctrl0, occ0, ctrl_of(mk('hB)));
    end
    stall0 = 1; d0 = mk('hC); c0 = ctrl_of(mk('hC));
    #1;
    n_checks++;
    if (in_ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL noskid_stall_ready: got rdy=%b expected 0", in_ready0);
    end
    cyc();
    n_checks++;
    if (out_data0 !== mk('hB) || occ0 !== 2'd1) begin
      n_fail++;
      $display("FAIL noskid_stall_hold: got d=%h occ=%0d expected B/1", out_data0, occ0);
    end
    v0 = 0; stall0 = 0;
    cyc();
    n_checks++;
    if (out_valid0 !== 1'b0 || occ0 !== 2'd0 || out_ctrl0 !== '0) begin
      n_fail++;
      $display("FAIL noskid_drain: got v=%b occ=%0d c=%h expected 0/0/0", out_valid0, occ0, out_ctrl0);
    end
  endtask

  task automatic test_random();
    int unsigned cnt;
    cnt = 32'h100;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, cnt, $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      cnt++;
      cyc();
    end
    drive(0, 0, 0, 1, 0);
    repeat (4) cyc();
    n_checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_leftover: got %0d pending v=%b expected 0/0", sb_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_reset_mid_full();
    test_no_skid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
